// File: rtl/multi_count_down_timer_pkg.sv
// multi_count_down_timer_pkg: channel state, packed BCD time and BCD helpers shared by the timer.
package multi_count_down_timer_pkg;

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_RING} state_t;

    typedef struct packed {
        logic [7:0] hh;
        logic [7:0] mm;
        logic [7:0] ss;
    } bcd_time_t;

    localparam logic [3:0] BCD_DIGIT_MAX = 4'd9;
    localparam logic [3:0] BCD_TENS_MAX_MS = 4'd5;

    function automatic logic bcd_valid(bcd_time_t t);
        return t.hh[7:4] <= BCD_DIGIT_MAX && t.hh[3:0] <= BCD_DIGIT_MAX &&
               t.mm[7:4] <= BCD_TENS_MAX_MS && t.mm[3:0] <= BCD_DIGIT_MAX &&
               t.ss[7:4] <= BCD_TENS_MAX_MS && t.ss[3:0] <= BCD_DIGIT_MAX;
    endfunction

    function automatic logic [7:0] bcd_dec2(logic [7:0] d, logic [7:0] wrap);
        return d == 8'h00 ? wrap : d[3:0] == 4'd0 ? {d[7:4] - 4'd1, 4'd9} : d - 8'd1;
    endfunction

    // One-second BCD decrement; a zero field wraps and borrows from the next field up.
    function automatic bcd_time_t bcd_dec(bcd_time_t t);
        bcd_time_t r;
        r = t;
        r.ss = bcd_dec2(t.ss, 8'h59);
        if (t.ss == 8'h00) r.mm = bcd_dec2(t.mm, 8'h59);
        if (t.ss == 8'h00 && t.mm == 8'h00) r.hh = bcd_dec2(t.hh, 8'h99);
        return r;
    endfunction

endpackage

// File: rtl/multi_count_down_timer_cdt_channel.sv
// cdt_channel: one countdown channel -- FSM, prescaler, BCD decrement and ring pulse counter.
module cdt_channel
    import multi_count_down_timer_pkg::*;
#(
    parameter int CLK_HZ   = 1000,
    parameter int RING_SEC = 5
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      i_load,
    input  logic      i_en,
    input  logic      i_auto,
    input  bcd_time_t i_time,
    output bcd_time_t o_time,
    output logic      o_ring,
    output logic      o_busy
);

    localparam int PW   = CLK_HZ > 1 ? $clog2(CLK_HZ) : 1;
    localparam int RCYC = RING_SEC * CLK_HZ;
    localparam int RW   = RCYC > 1 ? $clog2(RCYC) : 1;

    state_t          r_state;
    bcd_time_t       r_time;
    bcd_time_t       r_reload;
    logic [PW-1:0]   r_pre;
    logic            r_ring;
    logic [RW-1:0]   r_ring_cnt;

    logic      w_tick;
    logic      w_ring_done;
    bcd_time_t w_next;

    assign w_tick      = r_state == ST_RUN && i_en && r_pre == PW'(CLK_HZ - 1);
    assign w_ring_done = r_ring && r_ring_cnt == '0;
    assign w_next      = bcd_dec(r_time);

    // Ring runs on its own counter so an auto-reloaded channel can ring while back in RUN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_time     <= '0;
            r_reload   <= '0;
            r_pre      <= '0;
            r_ring     <= 1'b0;
            r_ring_cnt <= '0;
        end else if (i_load) begin
            r_state    <= i_time == '0 ? ST_IDLE : ST_RUN;
            r_time     <= i_time;
            r_reload   <= i_time;
            r_pre      <= '0;
            r_ring     <= 1'b0;
            r_ring_cnt <= '0;
        end else begin
            if (w_ring_done) r_ring <= 1'b0;
            else if (r_ring) r_ring_cnt <= r_ring_cnt - 1'b1;
            if (w_ring_done && r_state == ST_RING) r_state <= ST_IDLE;
            if (r_state == ST_RUN && i_en) r_pre <= w_tick ? '0 : r_pre + 1'b1;
            if (w_tick) begin
                if (w_next != '0) begin
                    r_time <= w_next;
                end else begin
                    r_ring     <= 1'b1;
                    r_ring_cnt <= RW'(RCYC - 1);
                    r_time     <= i_auto ? r_reload : '0;
                    r_state    <= i_auto ? ST_RUN : ST_RING;
                end
            end
        end
    end

    assign o_time = r_time;
    assign o_ring = r_ring;
    assign o_busy = r_state == ST_RUN;

endmodule

// File: rtl/multi_count_down_timer.sv
// multi_count_down_timer: N_CH independent BCD countdown timers with shared load bus and display mux.
// Optional TIMER_AUTO_RELOAD_EN adds per-channel auto_reload on expiry.
module multi_count_down_timer
    import multi_count_down_timer_pkg::*;
#(
    parameter int N_CH     = 2,
    parameter int CLK_HZ   = 1000,
    parameter int RING_SEC = 5
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [N_CH-1:0]                     load,
    input  logic [N_CH-1:0]                     clock_en,
`ifdef TIMER_AUTO_RELOAD_EN
    input  logic [N_CH-1:0]                     auto_reload,
`endif
    input  logic [7:0]                          hour_bcd_in,
    input  logic [7:0]                          minute_bcd_in,
    input  logic [7:0]                          second_bcd_in,
    input  logic [(N_CH > 1 ? $clog2(N_CH) : 1)-1:0] disp_sel,
    output logic [7:0]                          hour_out_bcd,
    output logic [7:0]                          minute_out_bcd,
    output logic [7:0]                          second_out_bcd,
    output logic [N_CH-1:0]                     ring,
    output logic [N_CH-1:0]                     busy,
    output logic                                load_err
);

    localparam int SW = N_CH > 1 ? $clog2(N_CH) : 1;

    bcd_time_t       w_in;
    bcd_time_t       w_time [N_CH];
    bcd_time_t       w_disp;
    logic            w_valid;
    logic [N_CH-1:0] w_load;
    logic [N_CH-1:0] w_auto;
    logic            r_load_err;

    assign w_in    = '{hh: hour_bcd_in, mm: minute_bcd_in, ss: second_bcd_in};
    assign w_valid = bcd_valid(w_in);
    assign w_load  = load & {N_CH{w_valid}};

`ifdef TIMER_AUTO_RELOAD_EN
    assign w_auto = auto_reload;
`else
    assign w_auto = '0;
`endif

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        cdt_channel #(.CLK_HZ(CLK_HZ), .RING_SEC(RING_SEC)) u_ch (
            .clk    (clk),
            .rst_n  (rst_n),
            .i_load (w_load[g]),
            .i_en   (clock_en[g]),
            .i_auto (w_auto[g]),
            .i_time (w_in),
            .o_time (w_time[g]),
            .o_ring (ring[g]),
            .o_busy (busy[g])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_load_err <= 1'b0;
        else r_load_err <= |load && !w_valid;
    end

    // Unmatched selects (disp_sel >= N_CH) fall through to zero.
    always_comb begin
        w_disp = '0;
        for (int i = 0; i < N_CH; i++)
            if (disp_sel == SW'(i)) w_disp = w_time[i];
    end

    assign hour_out_bcd   = w_disp.hh;
    assign minute_out_bcd = w_disp.mm;
    assign second_out_bcd = w_disp.ss;
    assign load_err       = r_load_err;

endmodule

// File: tb/tb_multi_count_down_timer.sv
// tb_multi_count_down_timer: directed checks with CLK_HZ=10, RING_SEC=2, N_CH=2.
// Auto-reload checks run only when TIMER_AUTO_RELOAD_EN is defined.
module tb_multi_count_down_timer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] load;
    logic [1:0] clock_en;
`ifdef TIMER_AUTO_RELOAD_EN
    logic [1:0] auto_reload;
`endif
    logic [7:0] hour_bcd_in, minute_bcd_in, second_bcd_in;
    logic       disp_sel;
    logic [7:0] hour_out_bcd, minute_out_bcd, second_out_bcd;
    logic [1:0] ring, busy;
    logic       load_err;

    int n_tests = 0;
    int n_fail  = 0;

    multi_count_down_timer #(.N_CH(2), .CLK_HZ(10), .RING_SEC(2)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .load           (load),
        .clock_en       (clock_en),
`ifdef TIMER_AUTO_RELOAD_EN
        .auto_reload    (auto_reload),
`endif
        .hour_bcd_in    (hour_bcd_in),
        .minute_bcd_in  (minute_bcd_in),
        .second_bcd_in  (second_bcd_in),
        .disp_sel       (disp_sel),
        .hour_out_bcd   (hour_out_bcd),
        .minute_out_bcd (minute_out_bcd),
        .second_out_bcd (second_out_bcd),
        .ring           (ring),
        .busy           (busy),
        .load_err       (load_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_load(input logic [1:0] mask, input logic [23:0] t);
        {hour_bcd_in, minute_bcd_in, second_bcd_in} = t;
        load = mask;
        @(negedge clk);
        load = 2'b00;
    endtask

    task automatic rd(input logic ch, output logic [23:0] v);
        disp_sel = ch;
        #1;
        v = {hour_out_bcd, minute_out_bcd, second_out_bcd};
    endtask

    initial begin
        logic [23:0] v;
        int n;
        rst_n = 1'b0;
        load = 2'b00;
        clock_en = 2'b11;
`ifdef TIMER_AUTO_RELOAD_EN
        auto_reload = 2'b00;
`endif
        {hour_bcd_in, minute_bcd_in, second_bcd_in} = 24'h0;
        disp_sel = 1'b0;
        tick(2);
        rd(0, v); check("rst_disp0", v, 24'h0);
        rd(1, v); check("rst_disp1", v, 24'h0);
        check("rst_ring", ring, 2'b00);
        check("rst_busy", busy, 2'b00);
        check("rst_err", load_err, 1'b0);
        rst_n = 1'b1;
        tick(1);

        do_load(2'b01, 24'h000003);
        check("cd_busy", busy, 2'b01);
        rd(0, v); check("cd_3", v, 24'h000003);
        tick(10); rd(0, v); check("cd_2", v, 24'h000002);
        tick(10); rd(0, v); check("cd_1", v, 24'h000001);
        check("cd_noring", ring, 2'b00);
        tick(10); rd(0, v); check("cd_0", v, 24'h000000);
        check("cd_busy_ring", busy, 2'b00);
        n = 0;
        while (ring[0] && n < 40) begin
            n++;
            @(negedge clk);
        end
        check("ring_len", n, 20);
        check("ring_idle_busy", busy, 2'b00);

        do_load(2'b01, 24'h010000);
        tick(10); rd(0, v); check("borrow_hr", v, 24'h005959);
        do_load(2'b01, 24'h000100);
        tick(10); rd(0, v); check("borrow_min", v, 24'h000059);
        do_load(2'b01, 24'h000010);
        tick(10); rd(0, v); check("borrow_tens", v, 24'h000009);

        do_load(2'b01, 24'h000005);
        tick(3);
        clock_en[0] = 1'b0;
        tick(50); rd(0, v); check("pause_val", v, 24'h000005);
        check("pause_busy", busy, 2'b01);
        clock_en[0] = 1'b1;
        tick(46); rd(0, v); check("resume_1", v, 24'h000001);
        check("resume_noring", ring[0], 1'b0);
        tick(1); rd(0, v); check("resume_0", v, 24'h000000);
        check("resume_ring", ring[0], 1'b1);
        tick(25);

        clock_en = 2'b00;
        do_load(2'b01, 24'h000007);
        check("valid_err", load_err, 1'b0);
        do_load(2'b01, 24'h006000);
        check("err_min60", load_err, 1'b1);
        rd(0, v); check("err_min60_val", v, 24'h000007);
        tick(1); check("err_pulse", load_err, 1'b0);
        do_load(2'b01, 24'h00000A);
        check("err_sec0A", load_err, 1'b1);
        rd(0, v); check("err_sec0A_val", v, 24'h000007);
        do_load(2'b01, 24'h9A0000);
        check("err_hr9A", load_err, 1'b1);
        do_load(2'b01, 24'h995959);
        check("max_err", load_err, 1'b0);
        rd(0, v); check("max_val", v, 24'h995959);
        do_load(2'b01, 24'h000000);
        check("zero_idle", busy, 2'b00);

        clock_en = 2'b11;
        do_load(2'b11, 24'h000002);
        check("dual_busy", busy, 2'b11);
        rd(1, v); check("dual_val1", v, 24'h000002);
        tick(10); rd(0, v); check("dual_dec0", v, 24'h000001);
        rd(1, v); check("dual_dec1", v, 24'h000001);
        tick(40);

        do_load(2'b10, 24'h001000);
        do_load(2'b01, 24'h000001);
        tick(10); check("mid_ring", ring, 2'b01);
        tick(5);
        do_load(2'b01, 24'h000009);
        check("load_drop_ring", ring, 2'b00);
        check("load_drop_busy", busy, 2'b11);
        do_load(2'b01, 24'h000001);
        tick(10); check("ring_again", ring, 2'b01);
        tick(3);
        rst_n = 1'b0;
        #1;
        check("arst_ring", ring, 2'b00);
        check("arst_busy", busy, 2'b00);
        check("arst_err", load_err, 1'b0);
        rd(0, v); check("arst_disp0", v, 24'h0);
        rd(1, v); check("arst_disp1", v, 24'h0);
        @(negedge clk);
        rst_n = 1'b1;
        tick(1);
        rd(1, v); check("post_rst_ch1", v, 24'h0);
        check("post_rst_ring", ring, 2'b00);

`ifdef TIMER_AUTO_RELOAD_EN
        auto_reload = 2'b10;
        do_load(2'b10, 24'h000002);
        tick(20);
        check("ar_ring1", ring[1], 1'b1);
        check("ar_busy1", busy[1], 1'b1);
        rd(1, v); check("ar_val1", v, 24'h000002);
        tick(20);
        check("ar_ring2", ring[1], 1'b1);
        check("ar_busy2", busy[1], 1'b1);
        rd(1, v); check("ar_val2", v, 24'h000002);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
